// File: rtl/condlogic_pkg.sv
// condlogic_pkg
// Shared definitions for the condition logic and the ALU decoder:
//   - 4-bit condition-code values carried in Instr[31:28]
//   - bit positions of N, Z, C, V inside the 4-bit flag vector
//   - flag vector type
package condlogic_pkg;

   typedef logic [3:0] flags_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// condcheck
// Purely combinational evaluation of an instruction condition field
// against the architectural flags.
// Ports:
//   Cond   - 4-bit condition field
//   Flags  - {N,Z,C,V}
//   CondEx - 1 when the instruction should execute
module condcheck
   import condlogic_pkg::*;
(
   input  logic [3:0] Cond,
   input  flags_t     Flags,
   output logic       CondEx
);

   logic neg, zero, carry, ovf, ge;

   // Split the flag vector and decode the condition; 4'hF is treated
   // as unconditional, same as AL.
   always_comb begin
      neg   = Flags[FLAG_N];
      zero  = Flags[FLAG_Z];
      carry = Flags[FLAG_C];
      ovf   = Flags[FLAG_V];
      ge    = (neg == ovf);
      CondEx = 1'b1;
      case (Cond)
         COND_EQ: CondEx = zero;
         COND_NE: CondEx = ~zero;
         COND_CS: CondEx = carry;
         COND_CC: CondEx = ~carry;
         COND_MI: CondEx = neg;
         COND_PL: CondEx = ~neg;
         COND_VS: CondEx = ovf;
         COND_VC: CondEx = ~ovf;
         COND_HI: CondEx = carry & ~zero;
         COND_LS: CondEx = ~carry | zero;
         COND_GE: CondEx = ge;
         COND_LT: CondEx = ~ge;
         COND_GT: CondEx = ~zero & ge;
         COND_LE: CondEx = zero | ~ge;
         default: CondEx = 1'b1;
      endcase
   end

endmodule

// File: rtl/condlogic_flopenr.sv
// flopenr
// Enabled flop with asynchronous active-high reset to zero.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, clears q
//   en    - load enable; q holds when low
//   d     - next value
//   q     - registered value
module flopenr #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset wins immediately; otherwise load only when enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/condlogic.sv
// condlogic
// Conditional-execution unit of a multicycle ARM-style controller. Holds
// the architectural flags, evaluates the instruction condition, and gates
// the FSM's write requests with the registered condition result.
// Ports:
//   clk, reset - clock and asynchronous active-high reset
//   Cond       - instruction condition field
//   ALUFlags   - {N,Z,C,V} produced by the ALU this cycle
//   FlagW      - flag-write request, [1] = N,Z  [0] = C,V
//   PCS        - instruction writes the PC
//   NextPC     - unconditional PC update from the FSM
//   RegW, MemW - FSM write requests
//   PCWrite, RegWrite, MemWrite - gated enables
//   Flags      - architectural {N,Z,C,V}
module condlogic
   import condlogic_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags
);

   logic [1:0] nz_d, nz_q;
   logic [1:0] cv_d, cv_q;
   logic       cond_ex_r_d, cond_ex_r_q;
   logic       cond_ex;
   logic [1:0] flag_write;

   assign Flags = {nz_q, cv_q};

   condcheck u_condcheck (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (cond_ex)
   );

   // Flag writes are qualified by the condition registered on the
   // previous edge, so the condition seen this cycle uses the old flags
   // and the new ones appear only after the edge.
   always_comb begin
      flag_write  = FlagW & {2{cond_ex_r_q}};
      nz_d        = ALUFlags[3:2];
      cv_d        = ALUFlags[1:0];
      cond_ex_r_d = cond_ex;
   end

   flopenr #(.WIDTH(2)) u_nz_reg (
      .clk   (clk),
      .reset (reset),
      .en    (flag_write[1]),
      .d     (nz_d),
      .q     (nz_q)
   );

   flopenr #(.WIDTH(2)) u_cv_reg (
      .clk   (clk),
      .reset (reset),
      .en    (flag_write[0]),
      .d     (cv_d),
      .q     (cv_q)
   );

   flopenr #(.WIDTH(1)) u_cond_ex_reg (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .d     (cond_ex_r_d),
      .q     (cond_ex_r_q)
   );

   // Write enables stay combinational in the requests; NextPC forces a
   // PC write even when the condition fails. Reset clears cond_ex_r_q,
   // which blocks register and memory writes while reset is high.
   always_comb begin
      RegWrite = RegW & cond_ex_r_q;
      MemWrite = MemW & cond_ex_r_q;
      PCWrite  = (PCS & cond_ex_r_q) | NextPC;
   end

endmodule

// File: tb/tb_condlogic.sv
// tb_condlogic
// Self-checking bench for condlogic: directed scenarios, a full
// condition/flag sweep, asynchronous reset checks and a randomized run,
// all compared against a behavioural model of the flag/condition rules.
module tb_condlogic;

   logic       clk;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, NextPC, RegW, MemW;
   logic       PCWrite, RegWrite, MemWrite;
   logic [3:0] Flags;

   int numCompared   = 0;
   int numMismatched = 0;

   // Reference state: architectural flags and the previous cycle's
   // condition outcome.
   logic [3:0] modelFlags;
   logic       modelPrevPass;

   condlogic dut (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .NextPC   (NextPC),
      .RegW     (RegW),
      .MemW     (MemW),
      .PCWrite  (PCWrite),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .Flags    (Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every comparison and report any difference.
   task automatic checkOutput(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Architectural meaning of each condition code.
   function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, then advance
   // the model across the rising edge.
   task automatic applyStimulus(input logic [3:0] c, input logic [3:0] alu,
                                input logic [1:0] fw, input logic pcs,
                                input logic npc, input logic rw, input logic mw);
      logic pass;
      Cond = c; ALUFlags = alu; FlagW = fw;
      PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
      @(negedge clk);
      pass = condHolds(c, modelFlags);
      checkOutput("CondEx",   {3'b0, dut.cond_ex}, {3'b0, pass});
      checkOutput("RegWrite", {3'b0, RegWrite}, {3'b0, rw & modelPrevPass});
      checkOutput("MemWrite", {3'b0, MemWrite}, {3'b0, mw & modelPrevPass});
      checkOutput("PCWrite",  {3'b0, PCWrite},  {3'b0, (pcs & modelPrevPass) | npc});
      checkOutput("Flags",    Flags, modelFlags);
      if (modelPrevPass && fw[1]) modelFlags[3:2] = alu[3:2];
      if (modelPrevPass && fw[0]) modelFlags[1:0] = alu[1:0];
      modelPrevPass = pass;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
      PCS = 1'b0; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1;
      modelFlags = 4'h0;
      modelPrevPass = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst RegWrite", {3'b0, RegWrite}, 4'h0);
      checkOutput("rst MemWrite", {3'b0, MemWrite}, 4'h0);
      checkOutput("rst PCWrite",  {3'b0, PCWrite},  4'h0);
      NextPC = 1'b1;
      #1;
      checkOutput("rst PCWrite=NextPC", {3'b0, PCWrite}, 4'h1);
      checkOutput("rst Flags", Flags, 4'h0);
      NextPC = 1'b0;
      reset = 1'b0;

      // First AL instruction: blocked in cycle 0, allowed in cycle 1
      applyStimulus(4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
      applyStimulus(4'hE, 4'h0, 2'b00, 0, 0, 1, 0);

      // Set Z, then EQ passes
      applyStimulus(4'hE, 4'h4, 2'b11, 0, 0, 0, 0);
      applyStimulus(4'hE, 4'h4, 2'b11, 0, 0, 0, 0);
      applyStimulus(4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
      applyStimulus(4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
      checkOutput("EQ regwrite", {3'b0, RegWrite}, 4'h1);

      // NE fails with Z set; NextPC still forces the PC write
      applyStimulus(4'h1, 4'h0, 2'b00, 1, 0, 0, 1);
      applyStimulus(4'h1, 4'h0, 2'b00, 1, 0, 0, 1);
      applyStimulus(4'h1, 4'h0, 2'b00, 1, 1, 0, 1);

      // Partial write: NZ updated, CV kept
      applyStimulus(4'hE, 4'hA, 2'b11, 0, 0, 0, 0);
      applyStimulus(4'hE, 4'hA, 2'b11, 0, 0, 0, 0);
      checkOutput("flags 1010", Flags, 4'hA);
      applyStimulus(4'hA, 4'h0, 2'b00, 0, 0, 0, 0);
      applyStimulus(4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
      applyStimulus(4'hE, 4'h5, 2'b10, 0, 0, 0, 0);
      checkOutput("partial write", Flags, 4'h6);
      applyStimulus(4'hA, 4'h0, 2'b00, 0, 0, 0, 0);
      applyStimulus(4'hB, 4'h0, 2'b00, 0, 0, 1, 1);

      // Every condition against every flag value
      for (int f = 0; f < 16; f++) begin
         applyStimulus(4'hE, f[3:0], 2'b11, 0, 0, 0, 0);
         applyStimulus(4'hE, f[3:0], 2'b11, 0, 0, 0, 0);
         for (int c = 0; c < 16; c++) begin
            applyStimulus(c[3:0], 4'h0, 2'b00, 1, 0, 1, 1);
         end
      end

      // Asynchronous reset mid-cycle with flags 1111 and CondExR=1
      applyStimulus(4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
      applyStimulus(4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
      checkOutput("pre-reset flags", Flags, 4'hF);
      RegW = 1'b1; MemW = 1'b1; NextPC = 1'b0; PCS = 1'b1;
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'h5;
      #1;
      checkOutput("pre-reset RegWrite", {3'b0, RegWrite}, 4'h1);
      reset = 1'b1;
      #1;
      checkOutput("async Flags",    Flags, 4'h0);
      checkOutput("async RegWrite", {3'b0, RegWrite}, 4'h0);
      checkOutput("async MemWrite", {3'b0, MemWrite}, 4'h0);
      checkOutput("async PCWrite",  {3'b0, PCWrite},  4'h0);
      NextPC = 1'b1;
      #1;
      checkOutput("async PCWrite=NextPC", {3'b0, PCWrite}, 4'h1);
      @(posedge clk);
      #1;
      checkOutput("reset drops flag write", Flags, 4'h0);
      reset = 1'b0;
      modelFlags = 4'h0;
      modelPrevPass = 1'b0;
      // First edge after reset evaluates against flags 0000
      applyStimulus(4'h0, 4'hF, 2'b11, 0, 0, 1, 0);
      applyStimulus(4'hE, 4'hF, 2'b11, 0, 0, 1, 0);
      applyStimulus(4'hE, 4'h0, 2'b00, 0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 3), $urandom_range(0, 1),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                       $urandom_range(0, 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               numCompared, numMismatched);
      $finish;
   end

endmodule
